sd_sector_cache: RTL and testbench

- Single-sector (512-byte) buffer between user logic and sd_controller.
- LOAD fetches one sector from the card into local RAM; host logic then reads and modifies bytes at random through a simple RAM port.
- FLUSH writes the buffer back to a sector.
- Sits directly upstream and downstream of sd_controller: it drives rd, wr, address and din, and consumes dout, byte_available, ready_for_next_byte and ready.

---
 rtl/sd_pkg.sv | 20 ++
 rtl/sd_sector_ram.sv | 35 +++
 rtl/sd_sector_cache.sv | 215 +++++++++++++++++++++
 tb/tb_sd_sector_cache.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared constants for the SD sector cache: sector geometry, addressing
// shift defaults and the cache FSM state encoding.
package sd_pkg;

    localparam int SECTOR_BYTES = 512;

    // Sector number to controller address: SDSC cards take byte addresses,
    // SDHC/SDXC cards take block addresses.
    localparam int SECTOR_SHIFT_SDSC = 9;
    localparam int SECTOR_SHIFT_SDHC = 0;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LOAD_REQ   = 3'd1;
    localparam logic [2:0] ST_LOAD_DATA  = 3'd2;
    localparam logic [2:0] ST_LOAD_END   = 3'd3;
    localparam logic [2:0] ST_FLUSH_REQ  = 3'd4;
    localparam logic [2:0] ST_FLUSH_DATA = 3'd5;
    localparam logic [2:0] ST_FLUSH_END  = 3'd6;

endpackage

// File: rtl/sd_sector_ram.sv
// 512x8 single-port sector buffer with a registered read port.
// A read and a write to the same address in one cycle return the old data.
module sd_sector_ram
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] addr,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] mem_reg [SECTOR_BYTES];
    logic [7:0] rdata_reg;

    // Write port; array contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[addr] <= wdata;
        end
    end

    // Registered read (read-before-write); only the output register is reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_reg <= '0;
        end else begin
            rdata_reg <= mem_reg[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/sd_sector_cache.sv
// Single-sector cache between user logic and sd_controller. LOAD copies one
// card sector into the local buffer, FLUSH writes the buffer back. The host
// owns the RAM port while idle; the FSM owns it while busy.
module sd_sector_cache
    import sd_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
    parameter int          SECTOR_SHIFT   = SECTOR_SHIFT_SDSC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_load,
    input  logic        cmd_flush,
    input  logic [31:0] cmd_sector,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        dirty,
    input  logic [8:0]  host_addr,
    input  logic        host_we,
    input  logic [7:0]  host_wdata,
    output logic [7:0]  host_rdata,
    input  logic        sd_ready,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic [31:0] sd_address,
    input  logic [7:0]  sd_dout,
    input  logic        sd_byte_available,
    output logic [7:0]  sd_din,
    input  logic        sd_ready_for_next_byte
);

    logic [2:0]  state_reg;
    logic [9:0]  idx_reg;
    logic [23:0] tmo_reg;
    logic        skip_first_reg;
    logic        rfnb_d_reg;
    logic        load_din_reg;
    logic        busy_reg, done_reg, err_reg, dirty_reg;
    logic        sd_rd_reg, sd_wr_reg;
    logic [31:0] sd_address_reg;
    logic [7:0]  sd_din_reg;
    logic        host_view_reg;
    logic [7:0]  host_hold_reg;

    logic [8:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        idle;
    logic        rfnb_rise;
    logic        timeout_hit;
    logic [9:0]  idx_plus1;

    assign idle        = (state_reg == ST_IDLE);
    assign rfnb_rise   = sd_ready_for_next_byte & ~rfnb_d_reg;
    assign timeout_hit = !idle && (tmo_reg == TIMEOUT_CYCLES - 24'd1);
    assign idx_plus1   = idx_reg + 10'd1;

    // RAM port mux: host while idle, FSM while busy. During FLUSH_DATA the
    // next byte is always addressed so a counted edge can load it at once.
    always_comb begin
        ram_addr  = host_addr;
        ram_we    = 1'b0;
        ram_wdata = host_wdata;
        if (idle) begin
            ram_we = host_we;
        end else begin
            ram_wdata = sd_dout;
            case (state_reg)
                ST_LOAD_DATA: begin
                    ram_addr = idx_reg[8:0];
                    ram_we   = sd_byte_available;
                end
                ST_FLUSH_REQ:  ram_addr = 9'd0;
                ST_FLUSH_DATA: ram_addr = idx_plus1[8:0];
                default:       ram_addr = idx_reg[8:0];
            endcase
        end
    end

    sd_sector_ram u_ram (
        .clk   (clk),
        .reset (reset),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Command FSM, controller handshake, timeout and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            tmo_reg        <= '0;
            skip_first_reg <= 1'b0;
            rfnb_d_reg     <= 1'b0;
            load_din_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            dirty_reg      <= 1'b0;
            sd_rd_reg      <= 1'b0;
            sd_wr_reg      <= 1'b0;
            sd_address_reg <= '0;
            sd_din_reg     <= '0;
        end else begin
            sd_rd_reg    <= 1'b0;
            sd_wr_reg    <= 1'b0;
            done_reg     <= 1'b0;
            load_din_reg <= 1'b0;
            rfnb_d_reg   <= sd_ready_for_next_byte;
            if (load_din_reg) begin
                sd_din_reg <= ram_rdata;
            end
            if (!idle) begin
                tmo_reg <= tmo_reg + 24'd1;
            end
            if (idle && host_we) begin
                dirty_reg <= 1'b1;
            end
            if (timeout_hit) begin
                err_reg   <= 1'b1;
                done_reg  <= 1'b1;
                busy_reg  <= 1'b0;
                state_reg <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (cmd_load || cmd_flush) begin
                            sd_address_reg <= cmd_sector << SECTOR_SHIFT;
                            err_reg        <= 1'b0;
                            busy_reg       <= 1'b1;
                            tmo_reg        <= '0;
                            state_reg      <= cmd_load ? ST_LOAD_REQ : ST_FLUSH_REQ;
                        end
                    end
                    ST_LOAD_REQ: begin
                        if (sd_ready) begin
                            sd_rd_reg <= 1'b1;
                            idx_reg   <= '0;
                            state_reg <= ST_LOAD_DATA;
                        end
                    end
                    ST_LOAD_DATA: begin
                        if (sd_byte_available) begin
                            idx_reg <= idx_plus1;
                            if (idx_plus1 == 10'(SECTOR_BYTES)) begin
                                state_reg <= ST_LOAD_END;
                            end
                        end
                    end
                    ST_FLUSH_REQ: begin
                        if (sd_ready) begin
                            sd_wr_reg      <= 1'b1;
                            idx_reg        <= '0;
                            skip_first_reg <= 1'b1;
                            load_din_reg   <= 1'b1;
                            state_reg      <= ST_FLUSH_DATA;
                        end
                    end
                    ST_FLUSH_DATA: begin
                        // The command-phase edge carries no data capture.
                        if (rfnb_rise) begin
                            if (skip_first_reg) begin
                                skip_first_reg <= 1'b0;
                            end else begin
                                idx_reg      <= idx_plus1;
                                load_din_reg <= 1'b1;
                                if (idx_plus1 == 10'(SECTOR_BYTES)) begin
                                    state_reg <= ST_FLUSH_END;
                                end
                            end
                        end
                    end
                    ST_LOAD_END, ST_FLUSH_END: begin
                        if (sd_ready) begin
                            dirty_reg <= 1'b0;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    // Host read view: live RAM output after a host-owned cycle, otherwise
    // the last host value is held so host_rdata stays stable while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            host_view_reg <= 1'b1;
            host_hold_reg <= '0;
        end else begin
            host_view_reg <= idle;
            if (host_view_reg) begin
                host_hold_reg <= ram_rdata;
            end
        end
    end

    assign host_rdata = host_view_reg ? ram_rdata : host_hold_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign dirty      = dirty_reg;
    assign sd_rd      = sd_rd_reg;
    assign sd_wr      = sd_wr_reg;
    assign sd_address = sd_address_reg;
    assign sd_din     = sd_din_reg;

endmodule

// File: tb/tb_sd_sector_cache.sv
// Directed + randomized bench for sd_sector_cache with an inline controller
// BFM and a byte-array reference model of the sector buffer.
module tb_sd_sector_cache;
    import sd_pkg::*;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic        reset;
    logic        cmd_load, cmd_flush;
    logic [31:0] cmd_sector;
    logic        busy, done, err, dirty;
    logic [8:0]  host_addr;
    logic        host_we;
    logic [7:0]  host_wdata, host_rdata;
    logic        sd_ready, sd_rd, sd_wr;
    logic [31:0] sd_address;
    logic [7:0]  sd_dout, sd_din;
    logic        sd_byte_available, sd_ready_for_next_byte;

    logic        b_cmd_load, b_cmd_flush;
    logic [31:0] b_cmd_sector;
    logic        b_busy, b_done, b_err, b_dirty;
    logic [8:0]  b_host_addr;
    logic        b_host_we;
    logic [7:0]  b_host_wdata, b_host_rdata;
    logic        b_sd_ready, b_sd_rd, b_sd_wr;
    logic [31:0] b_sd_address;
    logic [7:0]  b_sd_dout, b_sd_din;
    logic        b_sd_byte_available, b_sd_ready_for_next_byte;

    int checks = 0;
    int failures = 0;
    logic [7:0] model [512];
    logic [7:0] bmodel [512];

    sd_sector_cache #(.TIMEOUT_CYCLES(24'd50_000), .SECTOR_SHIFT(SECTOR_SHIFT_SDSC)) u_dut (
        .clk(clk), .reset(reset), .cmd_load(cmd_load), .cmd_flush(cmd_flush),
        .cmd_sector(cmd_sector), .busy(busy), .done(done), .err(err), .dirty(dirty),
        .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .sd_ready(sd_ready), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_address(sd_address), .sd_dout(sd_dout), .sd_byte_available(sd_byte_available),
        .sd_din(sd_din), .sd_ready_for_next_byte(sd_ready_for_next_byte)
    );

    sd_sector_cache #(.TIMEOUT_CYCLES(24'd1000), .SECTOR_SHIFT(SECTOR_SHIFT_SDHC)) u_dut_hc (
        .clk(clk), .reset(reset), .cmd_load(b_cmd_load), .cmd_flush(b_cmd_flush),
        .cmd_sector(b_cmd_sector), .busy(b_busy), .done(b_done), .err(b_err), .dirty(b_dirty),
        .host_addr(b_host_addr), .host_we(b_host_we), .host_wdata(b_host_wdata),
        .host_rdata(b_host_rdata), .sd_ready(b_sd_ready), .sd_rd(b_sd_rd), .sd_wr(b_sd_wr),
        .sd_address(b_sd_address), .sd_dout(b_sd_dout), .sd_byte_available(b_sd_byte_available),
        .sd_din(b_sd_din), .sd_ready_for_next_byte(b_sd_ready_for_next_byte)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic host_wr(input logic [8:0] a, input logic [7:0] d);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        tick();
        host_we = 1'b0;
        model[a] = d;
    endtask

    task automatic host_rd(input string tag, input logic [8:0] a);
        host_addr = a;
        tick();
        chk(tag, 32'(host_rdata), 32'(model[a]));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        chk(tag, 32'(done), 32'd1);
    endtask

    // LOAD through the BFM; optional same-cycle flush strobe and busy-time
    // injections (flush strobe, host write) that must have no effect.
    task automatic run_load(input logic [31:0] sector, input bit pattern, input bit both, input bit inject);
        int n;
        bit wr_seen;
        logic [7:0] d;
        cmd_sector = sector; cmd_load = 1'b1; cmd_flush = both;
        tick();
        cmd_load = 1'b0; cmd_flush = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_addr", sd_address, sector << 9);
        n = 0;
        while (sd_rd !== 1'b1 && n < 50) begin tick(); n++; end
        chk("load_rd_seen", 32'(sd_rd), 32'd1);
        sd_ready = 1'b0;
        wr_seen = sd_wr;
        tick();
        chk("load_rd_pulse", 32'(sd_rd), 32'd0);
        for (int i = 0; i < 512; i++) begin
            d = pattern ? (i[7:0] ^ 8'hA5) : 8'($urandom);
            sd_dout = d; sd_byte_available = 1'b1;
            if (inject && i == 50) cmd_flush = 1'b1;
            if (inject && i == 60) begin
                host_addr = 9'd5; host_wdata = ~model[5]; host_we = 1'b1;
            end
            tick();
            sd_byte_available = 1'b0; cmd_flush = 1'b0; host_we = 1'b0;
            model[i] = d;
            if (sd_wr) wr_seen = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
        end
        sd_dout = 8'hEE; sd_byte_available = 1'b1;
        tick();
        sd_byte_available = 1'b0;
        repeat (3) tick();
        chk("load_end_busy", 32'(busy), 32'd1);
        chk("load_end_nodone", 32'(done), 32'd0);
        sd_ready = 1'b1;
        wait_done("load_done");
        chk("load_idle", 32'(busy), 32'd0);
        chk("load_err", 32'(err), 32'd0);
        chk("load_dirty", 32'(dirty), 32'd0);
        tick();
        chk("load_done_pulse", 32'(done), 32'd0);
        chk("load_no_wr", 32'(wr_seen), 32'd0);
        $display("load sector=%0d both=%0d inject=%0d complete", sector, both, inject);
    endtask

    // FLUSH through the BFM with a spurious command-phase edge; abort_at>=0
    // asserts reset in place of that capture.
    task automatic run_flush(input logic [31:0] sector, input int abort_at);
        int n;
        int bad;
        logic [7:0] cap10;
        cmd_sector = sector; cmd_flush = 1'b1;
        tick();
        cmd_flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd1);
        chk("flush_addr", sd_address, sector << 9);
        n = 0;
        while (sd_wr !== 1'b1 && n < 50) begin tick(); n++; end
        chk("flush_wr_seen", 32'(sd_wr), 32'd1);
        sd_ready = 1'b0;
        tick();
        chk("flush_wr_pulse", 32'(sd_wr), 32'd0);
        repeat (3) tick();
        sd_ready_for_next_byte = 1'b1;
        repeat (2) tick();
        sd_ready_for_next_byte = 1'b0;
        bad = 0;
        cap10 = 8'h00;
        for (int k = 0; k < 512; k++) begin
            repeat (14) tick();
            if (k == abort_at) begin
                reset = 1'b1;
                tick();
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_wr", 32'(sd_wr), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_dirty", 32'(dirty), 32'd0);
                reset = 1'b0; sd_ready = 1'b1;
                tick();
                $display("flush sector=%0d aborted by reset at byte %0d", sector, k);
                return;
            end
            if (k == 10) cap10 = sd_din;
            if (sd_din !== model[k]) bad++;
            sd_ready_for_next_byte = 1'b1;
            repeat (2) tick();
            sd_ready_for_next_byte = 1'b0;
        end
        chk("flush_bad_bytes", 32'(bad), 32'd0);
        chk("flush_byte10", 32'(cap10), 32'h3C);
        repeat (3) tick();
        chk("flush_end_busy", 32'(busy), 32'd1);
        sd_ready = 1'b1;
        wait_done("flush_done");
        chk("flush_idle", 32'(busy), 32'd0);
        chk("flush_dirty", 32'(dirty), 32'd0);
        chk("flush_err", 32'(err), 32'd0);
        tick();
        chk("flush_done_pulse", 32'(done), 32'd0);
        $display("flush sector=%0d complete", sector);
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [8:0] a;
        logic [7:0] d;
        reset = 1'b1;
        cmd_load = 0; cmd_flush = 0; cmd_sector = 0;
        host_addr = 0; host_we = 0; host_wdata = 0;
        sd_ready = 1'b1; sd_dout = 0; sd_byte_available = 0; sd_ready_for_next_byte = 0;
        b_cmd_load = 0; b_cmd_flush = 0; b_cmd_sector = 0;
        b_host_addr = 0; b_host_we = 0; b_host_wdata = 0;
        b_sd_ready = 1'b1; b_sd_dout = 0; b_sd_byte_available = 0; b_sd_ready_for_next_byte = 0;
        for (int i = 0; i < 512; i++) begin model[i] = 8'h00; bmodel[i] = 8'h00; end
        repeat (3) tick();
        chk("rst_busy0", 32'(busy), 32'd0);
        chk("rst_done0", 32'(done), 32'd0);
        chk("rst_err0", 32'(err), 32'd0);
        chk("rst_dirty0", 32'(dirty), 32'd0);
        chk("rst_rd0", 32'(sd_rd), 32'd0);
        chk("rst_wr0", 32'(sd_wr), 32'd0);
        chk("rst_addr0", sd_address, 32'd0);
        chk("rst_din0", 32'(sd_din), 32'd0);
        chk("rst_rdata0", 32'(host_rdata), 32'd0);
        reset = 1'b0;
        tick();

        run_load(32'd3, 1'b1, 1'b0, 1'b1);
        chk("load_addr_600", sd_address, 32'h600);
        host_rd("rd_addr0", 9'd0);
        chk("rd_addr0_const", 32'(host_rdata), 32'hA5);
        host_rd("rd_addr511", 9'd511);
        chk("rd_addr511_const", 32'(host_rdata), 32'h5A);
        host_rd("rd_busy_we_ignored", 9'd5);
        for (int i = 0; i < 6; i++) host_rd("rd_rand", 9'($urandom));

        host_wr(9'd10, 8'h3C);
        chk("dirty_after_wr", 32'(dirty), 32'd1);
        for (int i = 0; i < 4; i++) host_wr(9'($urandom_range(11, 511)), 8'($urandom));
        a = 9'($urandom_range(11, 511));
        d = 8'($urandom);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        tick();
        host_we = 1'b0;
        chk("rdw_old_data", 32'(host_rdata), 32'(model[a]));
        model[a] = d;
        host_rd("rdw_new_data", a);
        host_rd("rd_addr10", 9'd10);
        chk("dirty_before_flush", 32'(dirty), 32'd1);
        run_flush(32'd3, -1);

        run_load(32'd20, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) host_rd("rd_rand2", 9'($urandom));

        for (int i = 0; i < 3; i++) host_wr(9'($urandom), 8'($urandom));
        chk("dirty_before_abort", 32'(dirty), 32'd1);
        run_flush(32'd8, 200);
        host_rd("rd_after_reset", 9'($urandom));
        run_load(32'd5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) host_rd("rd_rand3", 9'($urandom));

        // Timeout instance: stall after 100 bytes, then a clean load.
        b_cmd_sector = 32'h12345; b_cmd_load = 1'b1;
        tick();
        b_cmd_load = 1'b0;
        chk("hc_addr", b_sd_address, 32'h00012345);
        chk("hc_busy", 32'(b_busy), 32'd1);
        n = 0;
        while (b_sd_rd !== 1'b1 && n < 20) begin tick(); n++; end
        chk("hc_rd_seen", 32'(b_sd_rd), 32'd1);
        b_sd_ready = 1'b0;
        for (int i = 0; i < 100; i++) begin
            b_sd_dout = 8'($urandom); b_sd_byte_available = 1'b1;
            tick();
        end
        b_sd_byte_available = 1'b0;
        n = 0;
        while (b_done !== 1'b1 && n < 1500) begin tick(); n++; end
        chk("tmo_done", 32'(b_done), 32'd1);
        chk("tmo_err", 32'(b_err), 32'd1);
        chk("tmo_idle", 32'(b_busy), 32'd0);
        tick();
        chk("tmo_done_pulse", 32'(b_done), 32'd0);
        chk("tmo_err_sticky", 32'(b_err), 32'd1);
        $display("hc load sector=0x12345 timed out after %0d cycles", n);

        b_sd_ready = 1'b1; b_cmd_sector = 32'd7; b_cmd_load = 1'b1;
        tick();
        b_cmd_load = 1'b0;
        chk("hc_err_cleared", 32'(b_err), 32'd0);
        chk("hc_addr7", b_sd_address, 32'd7);
        n = 0;
        while (b_sd_rd !== 1'b1 && n < 20) begin tick(); n++; end
        chk("hc_rd_seen2", 32'(b_sd_rd), 32'd1);
        b_sd_ready = 1'b0;
        for (int i = 0; i < 512; i++) begin
            bmodel[i] = 8'($urandom);
            b_sd_dout = bmodel[i]; b_sd_byte_available = 1'b1;
            tick();
        end
        b_sd_byte_available = 1'b0;
        tick();
        b_sd_ready = 1'b1;
        n = 0;
        while (b_done !== 1'b1 && n < 20) begin tick(); n++; end
        chk("hc_done", 32'(b_done), 32'd1);
        chk("hc_err", 32'(b_err), 32'd0);
        chk("hc_idle", 32'(b_busy), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            a = 9'($urandom);
            b_host_addr = a;
            tick();
            chk("hc_rd_rand", 32'(b_host_rdata), 32'(bmodel[a]));
        end
        $display("hc load sector=7 complete");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
